dot_mac_array: RTL

//  Multi-lane pipelined dot-product MAC. Each accepted beat multiplies LANES operand pairs,

---
 rtl/dot_mac_array.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dot_mac_array.sv
// rtl/dot_mac_array.sv - multi-lane pipelined dot-product MAC with optional saturation
// Beats flow through a product stage (S1) and a lane-reduction stage (S2) before the accumulate.
module dot_mac_array #(
   parameter int WIDTH     = 16,
   parameter int LANES     = 4,
   parameter int ACC_WIDTH = 48,
   parameter bit SATURATE  = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*WIDTH-1:0] in_a,
   input  logic [LANES*WIDTH-1:0] in_b,
   input  logic                   in_signed,
   input  logic                   in_last,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [ACC_WIDTH-1:0]   res_data,
   output logic                   res_ovf
);
   localparam int PW = 2 * WIDTH;
   localparam int EW = ACC_WIDTH + 2;

   localparam logic [ACC_WIDTH-1:0] UMAX = {ACC_WIDTH{1'b1}};
   localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   logic                 busy;
   logic                 vec_open;
   logic                 mode;
   logic                 accept;
   logic                 beat_signed;

   logic [PW-1:0]        prod [LANES];
   logic [PW-1:0]        s1_prod [LANES];
   logic                 s1_valid;
   logic                 s1_last;
   logic                 s1_signed;
   logic [EW-1:0]        s1_sum;

   logic [EW-1:0]        s2_sum;
   logic                 s2_valid;
   logic                 s2_last;
   logic                 s2_signed;

   logic [ACC_WIDTH-1:0] acc;
   logic                 ovf;
   logic [EW-1:0]        acc_ext;
   logic [EW-1:0]        total;
   logic                 add_ovf;
   logic [ACC_WIDTH-1:0] acc_next;

   // busy covers the span from accepting a last beat until its result is taken
   assign in_ready    = ~busy & ~clr;
   assign accept      = in_valid & in_ready;
   assign beat_signed = vec_open ? mode : in_signed;

   // Operands are extended to PW bits so one PW x PW multiply serves both modes.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         prod[i] = {{WIDTH{beat_signed & in_a[i*WIDTH+WIDTH-1]}}, in_a[i*WIDTH +: WIDTH]}
                 * {{WIDTH{beat_signed & in_b[i*WIDTH+WIDTH-1]}}, in_b[i*WIDTH +: WIDTH]};
      end
   end

   always_comb begin
      s1_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         s1_sum = s1_sum + {{(EW-PW){s1_signed & s1_prod[i][PW-1]}}, s1_prod[i]};
      end
   end

   assign acc_ext = {{2{s2_signed & acc[ACC_WIDTH-1]}}, acc};
   assign total   = acc_ext + s2_sum;

   always_comb begin
      if (s2_signed) begin
         add_ovf = (total[EW-1:ACC_WIDTH-1] != 3'b000) && (total[EW-1:ACC_WIDTH-1] != 3'b111);
      end else begin
         add_ovf = (total[EW-1:ACC_WIDTH] != 2'b00);
      end
      acc_next = total[ACC_WIDTH-1:0];
      if (add_ovf && SATURATE) begin
         if (!s2_signed)       acc_next = UMAX;
         else if (total[EW-1]) acc_next = SMIN;
         else                  acc_next = SMAX;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy      <= 1'b0;
         vec_open  <= 1'b0;
         mode      <= 1'b0;
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         s1_signed <= 1'b0;
         for (int i = 0; i < LANES; i++) s1_prod[i] <= '0;
         s2_valid  <= 1'b0;
         s2_last   <= 1'b0;
         s2_signed <= 1'b0;
         s2_sum    <= '0;
         acc       <= '0;
         ovf       <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_ovf   <= 1'b0;
      end else if (clr) begin
         busy      <= 1'b0;
         vec_open  <= 1'b0;
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         acc       <= '0;
         ovf       <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         if (accept) begin
            vec_open  <= ~in_last;
            if (!vec_open) mode <= in_signed;
            if (in_last) busy <= 1'b1;
            s1_last   <= in_last;
            s1_signed <= beat_signed;
            for (int i = 0; i < LANES; i++) s1_prod[i] <= prod[i];
         end
         s1_valid <= accept;

         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_sum    <= s1_sum;
            s2_last   <= s1_last;
            s2_signed <= s1_signed;
         end

         // The closing beat publishes the result and leaves acc clean for the next vector.
         if (s2_valid) begin
            if (s2_last) begin
               res_data  <= acc_next;
               res_ovf   <= ovf | add_ovf;
               res_valid <= 1'b1;
               acc       <= '0;
               ovf       <= 1'b0;
            end else begin
               acc <= acc_next;
               ovf <= ovf | add_ovf;
            end
         end

         if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
         end
      end
   end
endmodule
